pixel_addr_scanner: RTL

Parametrised, sequential successor to the combinational pixel address calculator. It walks a rectangular pixel window in row-major order and emits one SDRAM byte address per accepted beat on a valid/ready stream. Row stride, window size, pixel size and base offset are all programmable per job. Addresses are formed incrementally, with one multiply per job, so no per-pixel multiplier is needed. It sits between the Julia worker's pixel scheduler and the SDRAM write path.

---
 rtl/pixel_addr_scanner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pixel_addr_scanner.sv
// Purpose: walks a width x height pixel window row-major, emitting one byte address per beat.
// Latency: start sampled at N -> LOAD at N+1 -> first beat at N+2; last accept at M -> done at M+1.
// Backpressure: valid/ready; a stalled beat holds x/y/address; one beat per cycle incl. row wrap.
//
// Ports:
//   clk, n_rst            clock, async active-low reset
//   start, clear          job request (IDLE only), synchronous abort (highest priority)
//   width, height, stride window size and row pitch in pixels (latched at start)
//   pixel_size, offset    bytes per pixel, byte address of pixel (0,0) (latched at start)
//   out_valid/out_ready   beat handshake; x, y, address describe the current beat
//   busy, done            high in LOAD/RUN; one-cycle pulse on normal completion
module pixel_addr_scanner #(
  parameter int XBITS     = 10,
  parameter int YBITS     = 10,
  parameter int PIXELBITS = 4,
  parameter int ADDRBITS  = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [XBITS-1:0]     width,
  input  logic [YBITS-1:0]     height,
  input  logic [XBITS-1:0]     stride,
  input  logic [PIXELBITS-1:0] pixel_size,
  input  logic [ADDRBITS-1:0]  offset,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [XBITS-1:0]     x,
  output logic [YBITS-1:0]     y,
  output logic [ADDRBITS-1:0]  address,
  output logic                 busy,
  output logic                 done
);

  localparam int PRODBITS = PIXELBITS + XBITS;
  localparam logic [XBITS-1:0] XONE = XBITS'(1);
  localparam logic [YBITS-1:0] YONE = YBITS'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state, state_nxt;

  // Job parameters captured at start; the live inputs are ignored afterwards.
  logic [XBITS-1:0]     width_q;
  logic [YBITS-1:0]     height_q;
  logic [XBITS-1:0]     stride_q;
  logic [PIXELBITS-1:0] psize_q;
  logic [ADDRBITS-1:0]  offset_q;

  logic [ADDRBITS-1:0]  row_step;
  logic [ADDRBITS-1:0]  row_base;
  logic [PRODBITS-1:0]  prod;

  logic accept;
  logic last_col;
  logic last_row;

  // The only multiply: one row pitch in bytes, computed once per job in LOAD.
  assign prod     = PRODBITS'(stride_q) * PRODBITS'(psize_q);
  assign accept   = out_valid && out_ready;
  assign last_col = (x == width_q - XONE);
  assign last_row = (y == height_q - YONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (width_q == '0 || height_q == '0) state_nxt = DONE;
        else                                 state_nxt = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (accept && last_col && last_row) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      width_q  <= '0;
      height_q <= '0;
      stride_q <= '0;
      psize_q  <= '0;
      offset_q <= '0;
      row_step <= '0;
      row_base <= '0;
      x        <= '0;
      y        <= '0;
      address  <= '0;
    end else if (!clear) begin
      case (state)
        IDLE: begin
          if (start) begin
            width_q  <= width;
            height_q <= height;
            stride_q <= stride;
            psize_q  <= pixel_size;
            offset_q <= offset;
          end
        end
        LOAD: begin
          row_step <= ADDRBITS'(prod);
          row_base <= offset_q;
          address  <= offset_q;
          x        <= '0;
          y        <= '0;
        end
        RUN: begin
          if (accept) begin
            if (!last_col) begin
              x       <= x + XONE;
              address <= address + ADDRBITS'(psize_q);
            end else if (!last_row) begin
              // Next row starts from the row base, not from the running address,
              // so stride > width needs no per-row correction term.
              x        <= '0;
              y        <= y + YONE;
              row_base <= row_base + row_step;
              address  <= row_base + row_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
